// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
// Purpose: frame state encoding, default timing constants and line levels
//          shared by the transmitter and the receiver.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DEF_CLKS_PER_BIT = 15;
  localparam int DEF_DATA_BITS    = 8;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  // Wide enough for DATA_BITS-1 (max 7) and STOP_BITS-1 (max 1).
  localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with end-of-bit tick
// Purpose: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle
//          of each bit period.
// Ports:   clk   - system clock
//          rst   - asynchronous active-high reset
//          en    - count enable (held low while the line is idle)
//          clear - restart the bit period from 0 on the next edge
//          tick  - high in the cycle where count == CLKS_PER_BIT-1
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && !clear && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter (start, LSB-first data, even parity, stop)
// Purpose: serialises one word per accepted request onto txd.
// Ports:   clk      - system clock, rising edge
//          rst      - asynchronous active-high reset, aborts any frame
//          tx_start - send request, only sampled while idle
//          tx_data  - word to send, captured on the accepting edge
//          txd      - serial line, idle high, driven straight from a flop
//          tx_busy  - high from the accepting edge until the frame ends
//          tx_done  - one-cycle pulse when the last stop bit completes
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  tick;

  assign accept = (state_q == IDLE) && tx_start;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != IDLE),
    .clear(accept),
    .tick (tick)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      txd_q     <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d   = START;
          shift_d   = tx_data;
          parity_d  = ^tx_data;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Output logic: decoded from the next state so the flopped outputs
  // change on the same edge as the state they describe.
  always_comb begin
    txd_d  = LINE_IDLE;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    unique case (state_d)
      START:   txd_d = START_LVL;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = parity_d;
      default: txd_d = LINE_IDLE;
    endcase
  end

  assign txd     = txd_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       start_r [3];
  logic [7:0] data_r  [3];
  logic       txd_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];

  int checks   = 0;
  int failures = 0;

  int cpb_of  [3] = '{15, 15, 4};
  int par_of  [3] = '{0, 1, 0};
  int stop_of [3] = '{1, 1, 2};

  logic tr_txd  [0:511];
  logic tr_busy [0:511];
  logic tr_done [0:511];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_tx #(.CLKS_PER_BIT(15), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .tx_start(start_r[0]), .tx_data(data_r[0]),
    .txd(txd_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx #(.CLKS_PER_BIT(15), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_start(start_r[1]), .tx_data(data_r[1]),
    .txd(txd_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .tx_start(start_r[2]), .tx_data(data_r[2]),
    .txd(txd_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int d);
    return (1 + 8 + par_of[d] + stop_of[d]) * cpb_of[d];
  endfunction

  function automatic logic exp_bit(input int d, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (par_of[d] != 0 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic kick(input int d, input logic [7:0] b, input bit hold);
    @(negedge clk);
    start_r[d] = 1'b1;
    data_r[d]  = b;
    @(posedge clk);
    #1;
    if (!hold) start_r[d] = 1'b0;
  endtask

  task automatic sample(input int d, input int j);
    tr_txd[j]  = txd_w[d];
    tr_busy[j] = busy_w[d];
    tr_done[j] = done_w[d];
  endtask

  // Mid-bit decode of a frame whose start bit begins at trace index base.
  task automatic check_frame(input int d, input logic [7:0] b, input int base, input string tag);
    int c;
    int nb;
    int glitches;
    logic [7:0] dec;
    c = cpb_of[d];
    nb = frame_len(d) / c;
    glitches = 0;
    dec = '0;
    for (int k = 0; k < nb; k++) begin
      check($sformatf("%s_bit%0d", tag, k), 32'(tr_txd[base + k*c + c/2]), 32'(exp_bit(d, b, k)));
      for (int j = 0; j < c; j++)
        if (tr_txd[base + k*c + j] !== exp_bit(d, b, k)) glitches++;
    end
    for (int k = 1; k <= 8; k++) dec[k-1] = tr_txd[base + k*c + c/2];
    check({tag, "_decoded"}, 32'(dec), 32'(b));
    check({tag, "_bit_hold"}, 32'(glitches), 32'd0);
  endtask

  task automatic run_frame(input int d, input logic [7:0] b, input string tag,
                           output int busy_n, output int done_at);
    int f;
    int done_n;
    f = frame_len(d);
    busy_n = 0;
    done_n = 0;
    done_at = -1;
    kick(d, b, 1'b0);
    for (int j = 0; j <= f + 2; j++) begin
      @(negedge clk);
      sample(d, j);
    end
    check_frame(d, b, 0, tag);
    for (int j = 0; j <= f + 2; j++) begin
      if (tr_busy[j] === 1'b1) busy_n++;
      if (tr_done[j] === 1'b1) begin
        done_n++;
        done_at = j;
      end
    end
    check({tag, "_done_count"}, 32'(done_n), 32'd1);
    check({tag, "_idle_after"}, 32'(tr_txd[f+1]), 32'd1);
    check({tag, "_busy_low_at_end"}, 32'(tr_busy[f]), 32'd0);
  endtask

  initial begin
    int f;
    int busy_n;
    int done_at;
    int cnt;
    int idx;
    logic [9:0] word;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_r[i] = 1'b0;
      data_r[i]  = 8'h00;
    end
    #2;
    check("reset_txd", 32'(txd_w[0]), 32'd1);
    check("reset_busy", 32'(busy_w[0]), 32'd0);
    check("reset_done", 32'(done_w[0]), 32'd0);
    #5 rst = 1'b0;
    @(negedge clk);
    check("post_reset_txd", 32'(txd_w[0]), 32'd1);

    // Single 0x55 frame, default configuration
    run_frame(0, 8'h55, "f55", busy_n, done_at);
    check("f55_busy_cycles", 32'(busy_n), 32'd150);
    check("f55_done_at", 32'(done_at), 32'd150);
    word = '0;
    for (int k = 0; k < 10; k++) word[k] = tr_txd[k*15 + 7];
    check("f55_pattern", 32'(word), 32'h2AA);

    // Back-to-back 0x00 then 0xFF with tx_start held high
    f = frame_len(0);
    kick(0, 8'h00, 1'b1);
    data_r[0] = 8'hFF;
    for (int j = 0; j <= 2*f + 2; j++) begin
      @(negedge clk);
      if (j == f + 2) start_r[0] = 1'b0;
      sample(0, j);
    end
    check_frame(0, 8'h00, 0, "b2b_first");
    check_frame(0, 8'hFF, f + 1, "b2b_second");
    check("b2b_gap_high", 32'(tr_txd[f]), 32'd1);
    idx = -1;
    for (int j = 9*15; j <= 2*f + 2; j++)
      if (idx < 0 && tr_txd[j] === 1'b0) idx = j;
    check("b2b_start_to_start", 32'(idx), 32'd151);
    cnt = 0;
    for (int j = 0; j <= 2*f + 2; j++) if (tr_done[j] === 1'b1) cnt++;
    check("b2b_done_count", 32'(cnt), 32'd2);
    repeat (5) @(negedge clk);

    // Request and data change 300 ns into an 0xA3 frame
    kick(0, 8'hA3, 1'b0);
    for (int j = 0; j <= f + 30; j++) begin
      @(negedge clk);
      if (j == 30) begin
        start_r[0] = 1'b1;
        data_r[0]  = 8'h12;
      end
      if (j == 31) start_r[0] = 1'b0;
      sample(0, j);
    end
    check_frame(0, 8'hA3, 0, "busy_req");
    cnt = 0;
    for (int j = f + 1; j <= f + 30; j++)
      if (tr_busy[j] === 1'b1 || tr_txd[j] === 1'b0) cnt++;
    check("busy_req_no_second_frame", 32'(cnt), 32'd0);

    // Even parity
    run_frame(1, 8'h07, "par07", busy_n, done_at);
    check("par07_parity_bit", 32'(tr_txd[9*15 + 7]), 32'd1);
    check("par07_busy_cycles", 32'(busy_n), 32'd165);
    check("par07_done_at", 32'(done_at), 32'd165);
    run_frame(1, 8'h03, "par03", busy_n, done_at);
    check("par03_parity_bit", 32'(tr_txd[9*15 + 7]), 32'd0);

    // Two stop bits, four clocks per bit
    run_frame(2, 8'h81, "stop2", busy_n, done_at);
    cnt = 0;
    for (int j = 36; j < 44; j++) if (tr_txd[j] === 1'b1) cnt++;
    check("stop2_stop_high_cycles", 32'(cnt), 32'd8);
    check("stop2_done_at", 32'(done_at), 32'd44);
    check("stop2_busy_cycles", 32'(busy_n), 32'd44);

    // Reset in the middle of data bit 4 of 0x0F
    kick(0, 8'h0F, 1'b0);
    for (int j = 0; j < 80; j++) @(negedge clk);
    check("rst_mid_pre_busy", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_txd", 32'(txd_w[0]), 32'd1);
    check("rst_mid_busy", 32'(busy_w[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1 || txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) cnt++;
    end
    check("rst_mid_quiet_after", 32'(cnt), 32'd0);
    run_frame(0, 8'h0F, "after_rst", busy_n, done_at);
    check("after_rst_done_at", 32'(done_at), 32'd150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
